// File: rtl/simd_bram_dp_if.sv
// Port bundle for simd_bram_dp: write port, read port and clear-sweep status.
interface simd_bram_dp_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 256
);
    localparam int AW = $clog2(DEPTH);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/simd_bram_dp.sv
// Simple-dual-port vector RAM with byte enables, write-first collisions and a post-reset clear sweep.
// Define BRAM_OUT_REG_EN to add an output register stage (read latency 2).
module simd_bram_dp #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 256
) (
    input logic          clk,
    input logic          rst,
    simd_bram_dp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [AW-1:0]         ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;

    // Power-of-two depths cannot address past the end of the array.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_part_range
        assign wr_in_range = (bus.wr_addr < AW'(DEPTH));
        assign rd_in_range = (bus.rd_addr < AW'(DEPTH));
    end

    assign wr_ok    = (state == READY) && bus.wr_en && wr_in_range;
    assign rd_ok    = (state == READY) && bus.rd_en;
    assign bus.busy = rst || (state == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else if (state == INIT) begin
            ptr <= ptr + AW'(1);
            if (ptr == AW'(DEPTH - 1))
                state <= READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            mem[ptr] <= '0;
        end else if (!rst && wr_ok) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.wr_be[b])
                    mem[bus.wr_addr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
            end
        end
    end

    // Write-first: a same-address write is merged into the word being read.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
            if (wr_ok && bus.wr_addr == bus.rd_addr) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (bus.wr_be[b])
                        rd_word[b*8 +: 8] = bus.wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= rd_ok;
            if (rd_ok)
                s_data <= rd_word;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic                  q_valid;
    logic [DATA_WIDTH-1:0] q_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            q_valid <= s_valid;
            if (s_valid)
                q_data <= s_data;
        end
    end

    assign bus.rd_valid = q_valid;
    assign bus.rd_data  = q_data;
`else
    assign bus.rd_valid = s_valid;
    assign bus.rd_data  = s_data;
`endif
endmodule

// File: tb/tb_simd_bram_dp.sv
// Self-checking bench for simd_bram_dp against an array-based reference with a read-latency queue.
module tb_simd_bram_dp;
    localparam int DW    = 128;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = DW / 8;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    simd_bram_dp_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    simd_bram_dp #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pv [LAT];
    logic [DW-1:0] pd [LAT];
    int            sweep_left = DEPTH;
    logic          exp_valid  = 1'b0;
    logic [DW-1:0] exp_data   = '0;
    logic          exp_busy   = 1'b1;

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock edge, predicting outputs from the inputs present before it.
    task automatic tick();
        logic          rv;
        logic [DW-1:0] rd;
        rv = 1'b0;
        rd = '0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
            sweep_left = DEPTH;
            exp_data   = '0;
        end else begin
            if (sweep_left > 0) begin
                sweep_left--;
            end else begin
                if (bus.wr_en && int'(bus.wr_addr) < DEPTH)
                    for (int b = 0; b < NB; b++)
                        if (bus.wr_be[b]) ref_mem[bus.wr_addr][b*8 +: 8] = bus.wr_data[b*8 +: 8];
                if (bus.rd_en) begin
                    rv = 1'b1;
                    rd = (int'(bus.rd_addr) < DEPTH) ? ref_mem[bus.rd_addr] : '0;
                end
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = rv;
            pd[0] = rd;
        end
        @(posedge clk);
        #1;
        exp_valid = pv[LAT-1];
        if (exp_valid) exp_data = pd[LAT-1];
        exp_busy = rst || (sweep_left > 0);
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
        rst = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            bus.wr_en   = (n < 4);
            bus.wr_addr = AW'(3);
            bus.wr_data = rand_word();
            bus.wr_be   = '1;
            n++;
            tick();
        end
        idle();
        tests++; if (n != DEPTH) begin fails++; $display("FAIL busy_length: got %0d expected %0d", n, DEPTH); end
        tests++; if (bus.busy !== exp_busy) begin fails++; $display("FAIL busy_release: got %b expected %b", bus.busy, exp_busy); end
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(3);
        tick();
        idle();
        repeat (LAT - 1) tick();
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL clear_rd_valid: got %b expected 1", bus.rd_valid); end
        tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL clear_rd_data: got %h expected 0", bus.rd_data); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] a5;
        a5 = {NB{8'hA5}};
        bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = a5; bus.wr_be = '1;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        idle();
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k > 1) tick();
            tests++; if (bus.rd_valid !== (k == LAT)) begin fails++; $display("FAIL basic_valid_c%0d: got %b expected %b", k, bus.rd_valid, (k == LAT)); end
            if (k == LAT) begin
                tests++; if (bus.rd_data !== a5) begin fails++; $display("FAIL basic_data: got %h expected %h", bus.rd_data, a5); end
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] want;
        want = {{8{8'h5A}}, {8{8'hFF}}};
        bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = {NB{8'h5A}}; bus.wr_be = '1;
        tick();
        bus.wr_data = '1; bus.wr_be = 16'h00FF;
        tick();
        bus.wr_be = '0; bus.wr_data = rand_word();
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rd_addr = AW'(2);
        tick();
        idle();
        repeat (LAT - 1) tick();
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL be_valid: got %b expected 1", bus.rd_valid); end
        tests++; if (bus.rd_data !== want) begin fails++; $display("FAIL be_data: got %h expected %h", bus.rd_data, want); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] w;
        logic [NB-1:0] be;
        bus.wr_en = 1'b1; bus.wr_addr = AW'(4); bus.wr_data = 128'h1234; bus.wr_be = '1;
        bus.rd_en = 1'b1; bus.rd_addr = AW'(4);
        tick();
        idle();
        repeat (LAT - 1) tick();
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL coll_valid: got %b expected 1", bus.rd_valid); end
        tests++; if (bus.rd_data !== 128'h1234) begin fails++; $display("FAIL coll_data: got %h expected %h", bus.rd_data, 128'h1234); end
        w  = rand_word();
        be = NB'($urandom);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(4); bus.wr_data = w; bus.wr_be = be;
        bus.rd_en = 1'b1; bus.rd_addr = AW'(4);
        tick();
        idle();
        repeat (LAT - 1) tick();
        tests++; if (bus.rd_data !== exp_data) begin fails++; $display("FAIL coll_partial: got %h expected %h", bus.rd_data, exp_data); end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] want [3];
        want[0] = {NB{8'hA5}};
        want[1] = {{8{8'h5A}}, {8{8'hFF}}};
        want[2] = '0;
        for (int i = 1; i <= 5; i++) begin
            bus.rd_en   = (i <= 3);
            bus.rd_addr = AW'(i);
            tick();
            idle();
            if (i >= LAT && i <= LAT + 2) begin
                tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL stream_valid_c%0d: got %b expected 1", i, bus.rd_valid); end
                tests++; if (bus.rd_data !== want[i-LAT]) begin fails++; $display("FAIL stream_data_c%0d: got %h expected %h", i, bus.rd_data, want[i-LAT]); end
            end else begin
                tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL stream_idle_c%0d: got %b expected 0", i, bus.rd_valid); end
            end
        end
    endtask

    task automatic test_random();
        int bad_v, bad_d;
        bad_v = 0;
        bad_d = 0;
        for (int i = 0; i < 300; i++) begin
            bus.wr_en   = ($urandom_range(0, 1) == 1);
            bus.wr_addr = AW'($urandom_range(8, 15));
            bus.wr_data = rand_word();
            bus.wr_be   = NB'($urandom);
            bus.rd_en   = ($urandom_range(0, 2) != 0);
            bus.rd_addr = AW'($urandom_range(8, 15));
            tick();
            if (bus.rd_valid !== exp_valid) bad_v++;
            if (bus.rd_data !== exp_data) begin
                if (bad_d == 0) $display("FAIL random_data_c%0d: got %h expected %h", i, bus.rd_data, exp_data);
                bad_d++;
            end
        end
        idle();
        tests++; if (bad_v != 0) begin fails++; $display("FAIL random_valid: got %0d bad cycles expected 0", bad_v); end
        tests++; if (bad_d != 0) begin fails++; $display("FAIL random_data: got %0d bad cycles expected 0", bad_d); end
    endtask

    task automatic test_reset_mid();
        int stray, n;
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", bus.rd_valid); end
        tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL midrst_data: got %h expected 0", bus.rd_data); end
        stray = 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
            n++;
            tick();
            if (bus.rd_valid !== 1'b0) stray++;
        end
        idle();
        tests++; if (stray != 0) begin fails++; $display("FAIL midrst_stray_valid: got %0d pulses expected 0", stray); end
        tests++; if (n != DEPTH) begin fails++; $display("FAIL midrst_busy_length: got %0d expected %0d", n, DEPTH); end
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        idle();
        repeat (LAT - 1) tick();
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL midrst_read_valid: got %b expected 1", bus.rd_valid); end
        tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL midrst_read_data: got %h expected 0", bus.rd_data); end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        idle();
        test_reset();
        test_basic();
        test_byte_enable();
        test_collision();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
